// File: rtl/reg_file_param.sv
// Parametrised register file with latched source/destination pointers, auto-increment and pointer readback.
// Optional same-cycle write forwarding is enabled with `define REG_FILE_BYPASS_EN.
module reg_file_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 0,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             REGWRITE,
  input  logic             SETSRC,
  input  logic             SETDEST,
  input  logic             AUTOINC,
  input  logic [IDX_W-1:0] rt_index,
  input  logic [WIDTH-1:0] write_value,
  output logic [WIDTH-1:0] rs,
  output logic [WIDTH-1:0] rt,
  output logic [IDX_W-1:0] src_index,
  output logic [IDX_W-1:0] dest_index
);

  localparam logic [IDX_W:0]   DEPTH_V  = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam bit               ZERO_EN  = (ZERO_REG != 0);

  logic [WIDTH-1:0] regs_r [DEPTH];
  logic [IDX_W-1:0] src_r;
  logic [IDX_W-1:0] dest_r;
  logic [IDX_W-1:0] dest_nxt_s;
  logic [IDX_W-1:0] rt_safe_s;
  logic             rt_in_range_s;
  logic             we_s;

  // Index qualification and write-enable, including the hardwired-zero discard.
  always_comb begin
    rt_in_range_s = ({1'b0, rt_index} < DEPTH_V);
    if (rt_in_range_s) begin
      rt_safe_s = rt_index;
    end else begin
      rt_safe_s = '0;
    end
    if (ZERO_EN && (dest_r == '0)) begin
      we_s = 1'b0;
    end else begin
      we_s = REGWRITE;
    end
  end

  // Destination pointer next value: pointer load beats auto-increment.
  always_comb begin
    dest_nxt_s = dest_r;
    if (SETDEST && rt_in_range_s) begin
      dest_nxt_s = rt_index;
    end else if (REGWRITE && AUTOINC) begin
      if (dest_r == LAST_IDX) begin
        dest_nxt_s = '0;
      end else begin
        dest_nxt_s = dest_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end else begin
      dest_nxt_s = dest_r;
    end
  end

  // Pointer and register array state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      src_r  <= '0;
      dest_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      if (SETSRC && rt_in_range_s) begin
        src_r <= rt_index;
      end
      dest_r <= dest_nxt_s;
      if (we_s) begin
        regs_r[dest_r] <= write_value;
      end
    end
  end

  // Read ports; out-of-range rt reads zero.
  always_comb begin
`ifdef REG_FILE_BYPASS_EN
    if (we_s && (src_r == dest_r)) begin
      rs = write_value;
    end else begin
      rs = regs_r[src_r];
    end
    if (!rt_in_range_s) begin
      rt = '0;
    end else if (we_s && (rt_index == dest_r)) begin
      rt = write_value;
    end else begin
      rt = regs_r[rt_safe_s];
    end
`else
    rs = regs_r[src_r];
    if (rt_in_range_s) begin
      rt = regs_r[rt_safe_s];
    end else begin
      rt = '0;
    end
`endif
  end

  assign src_index  = src_r;
  assign dest_index = dest_r;

endmodule

// File: tb/tb_reg_file_param.sv
// Table-driven bench for reg_file_param: default instance plus a DEPTH=6, ZERO_REG=1 instance.
module tb_reg_file_param;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       REGWRITE = 1'b0, SETSRC = 1'b0, SETDEST = 1'b0, AUTOINC = 1'b0;
  logic [2:0] rt_index = 3'd0;
  logic [7:0] write_value = 8'd0;
  logic [7:0] rs, rt;
  logic [2:0] src_index, dest_index;

  logic       z_regwrite = 1'b0, z_setsrc = 1'b0, z_setdest = 1'b0, z_autoinc = 1'b0;
  logic [2:0] z_rt_index = 3'd0;
  logic [7:0] z_write_value = 8'd0;
  logic [7:0] z_rs, z_rt;
  logic [2:0] z_src_index, z_dest_index;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  reg_file_param u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .REGWRITE(REGWRITE), .SETSRC(SETSRC),
    .SETDEST(SETDEST), .AUTOINC(AUTOINC), .rt_index(rt_index),
    .write_value(write_value), .rs(rs), .rt(rt),
    .src_index(src_index), .dest_index(dest_index)
  );

  reg_file_param #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1)) u_dut_z (
    .CLK(CLK), .RESET_N(RESET_N), .REGWRITE(z_regwrite), .SETSRC(z_setsrc),
    .SETDEST(z_setdest), .AUTOINC(z_autoinc), .rt_index(z_rt_index),
    .write_value(z_write_value), .rs(z_rs), .rt(z_rt),
    .src_index(z_src_index), .dest_index(z_dest_index)
  );

  typedef struct {
    logic       rw, ss, sd, ai;
    logic [2:0] idx;
    logic [7:0] wv;
    logic [7:0] e_rs, e_rt;
    logic [2:0] e_src, e_dest;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rw, ss, sd, ai, input logic [2:0] idx, input logic [7:0] wv);
    @(negedge CLK);
    REGWRITE = rw; SETSRC = ss; SETDEST = sd; AUTOINC = ai;
    rt_index = idx; write_value = wv;
    @(posedge CLK);
    #1;
    REGWRITE = 1'b0; SETSRC = 1'b0; SETDEST = 1'b0; AUTOINC = 1'b0;
    #1;
  endtask

  task automatic zstep(input logic rw, ss, sd, ai, input logic [2:0] idx, input logic [7:0] wv);
    @(negedge CLK);
    z_regwrite = rw; z_setsrc = ss; z_setdest = sd; z_autoinc = ai;
    z_rt_index = idx; z_write_value = wv;
    @(posedge CLK);
    #1;
    z_regwrite = 1'b0; z_setsrc = 1'b0; z_setdest = 1'b0; z_autoinc = 1'b0;
    #1;
  endtask

  initial begin
    //             rw    ss    sd    ai    idx   wv      e_rs   e_rt   src   dest
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 8'd0,   8'd0,  8'd0,  3'd6, 3'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 8'd0,   8'd0,  8'd0,  3'd6, 3'd5};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 8'd26,  8'd0,  8'd26, 3'd6, 3'd5};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 8'd0,   8'd0,  8'd0,  3'd6, 3'd6};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 8'd10,  8'd10, 8'd10, 3'd6, 3'd7};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 8'd11,  8'd10, 8'd11, 3'd6, 3'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'd12,  8'd10, 8'd12, 3'd6, 3'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 8'd0,   8'd10, 8'd11, 3'd6, 3'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'd0,   8'd10, 8'd0,  3'd6, 3'd2};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 8'd99,  8'd10, 8'd0,  3'd6, 3'd4};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0,   8'd10, 8'd99, 3'd6, 3'd4};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 8'd0,   8'd0,  8'd0,  3'd3, 3'd3};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 8'hA5,  8'hA5, 8'hA5, 3'd3, 3'd3};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'hFF,  8'hFF, 8'd12, 3'd3, 3'd4};

    // Reset state
    #12;
    check("reset_rs", 32'(rs), 32'd0);
    check("reset_rt", 32'(rt), 32'd0);
    check("reset_src", 32'(src_index), 32'd0);
    check("reset_dest", 32'(dest_index), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Mid-cycle asynchronous reset after regs[3]=0x55
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 8'h55);
    check("pre_reset_rt3", 32'(rt), 32'h55);
    @(negedge CLK);
    REGWRITE = 1'b1; SETDEST = 1'b1; rt_index = 3'd3; write_value = 8'h77;
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_rst_rs", 32'(rs), 32'd0);
    check("async_rst_rt", 32'(rt), 32'd0);
    check("async_rst_dest", 32'(dest_index), 32'd0);
    REGWRITE = 1'b0; SETDEST = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    check("post_rst_rt3", 32'(rt), 32'd0);

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].rw, vecs[i].ss, vecs[i].sd, vecs[i].ai, vecs[i].idx, vecs[i].wv);
      check($sformatf("v%0d_rs", i), 32'(rs), 32'(vecs[i].e_rs));
      check($sformatf("v%0d_rt", i), 32'(rt), 32'(vecs[i].e_rt));
      check($sformatf("v%0d_src", i), 32'(src_index), 32'(vecs[i].e_src));
      check($sformatf("v%0d_dest", i), 32'(dest_index), 32'(vecs[i].e_dest));
    end

    // Forwarding: src=dest=5, regs[5]=1, then write 42
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 8'd1);
    check("byp_setup_rs", 32'(rs), 32'd1);
    @(negedge CLK);
    REGWRITE = 1'b1; write_value = 8'd42; rt_index = 3'd5;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("byp_pre_rs", 32'(rs), 32'd42);
    check("byp_pre_rt", 32'(rt), 32'd42);
`else
    check("byp_pre_rs", 32'(rs), 32'd1);
    check("byp_pre_rt", 32'(rt), 32'd1);
`endif
    @(posedge CLK);
    #1;
    REGWRITE = 1'b0;
    #1;
    check("byp_post_rs", 32'(rs), 32'd42);

    // ZERO_REG=1, DEPTH=6 instance
    zstep(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'd77);
    check("z_reg0_rt", 32'(z_rt), 32'd0);
    check("z_inc_past0", 32'(z_dest_index), 32'd1);
    zstep(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'd33);
    check("z_reg1_rt", 32'(z_rt), 32'd33);
    zstep(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0);
    check("z_src1", 32'(z_src_index), 32'd1);
    zstep(1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 8'd0);
    check("z_src_oor_hold", 32'(z_src_index), 32'd1);
    check("z_rt_oor", 32'(z_rt), 32'd0);
    check("z_rs_after_oor", 32'(z_rs), 32'd33);
    zstep(1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 8'd0);
    check("z_dest_oor_hold", 32'(z_dest_index), 32'd1);
    zstep(1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 8'd0);
    zstep(1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 8'd9);
    check("z_wrap_rt5", 32'(z_rt), 32'd9);
    check("z_wrap_dest", 32'(z_dest_index), 32'd0);
    zstep(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'd4);
    check("z_discard_rt0", 32'(z_rt), 32'd0);
    check("z_discard_dest", 32'(z_dest_index), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
